// File: rtl/kamikaze_rf_sched_if.sv
// kamikaze_rf_sched_if: read/write request, response and single-port RAM signals of the register-file scheduler.
// Port directions are named from the scheduler's point of view (slave modport).
interface kamikaze_rf_sched_if;
  logic        rd_valid_i;
  logic        rd_ready_o;
  logic [4:0]  rd_addr1_i;
  logic [4:0]  rd_addr2_i;
  logic        rd_rsp_valid_o;
  logic [31:0] rd_data1_o;
  logic [31:0] rd_data2_o;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [4:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [4:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  modport slave (
    input  rd_valid_i, rd_addr1_i, rd_addr2_i, wr_valid_i, wr_addr_i, wr_data_i, ram_rdata_i,
    output rd_ready_o, rd_rsp_valid_o, rd_data1_o, rd_data2_o, wr_ready_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
  modport master (
    output rd_valid_i, rd_addr1_i, rd_addr2_i, wr_valid_i, wr_addr_i, wr_data_i, ram_rdata_i,
    input  rd_ready_o, rd_rsp_valid_o, rd_data1_o, rd_data2_o, wr_ready_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/kamikaze_rf_sched.sv
// kamikaze_rf_sched: shares one single-port RAM between two-operand register reads and writes, with read anti-starvation.
// Define KAMIKAZE_RF_WRBUF_EN to add a one-entry write buffer that accepts writes in any state.
module kamikaze_rf_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk_i,
  input logic                rst_n_i,
  kamikaze_rf_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD1, RD2, RSP} state_e;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_e      state_q, state_d;
  logic [4:0]  addr1_q, addr1_d, addr2_q, addr2_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data1_q, data1_d, data2_q, data2_d;
  logic        rsp_q;
  logic        idle, starve, rd_grant, wr_grant, wr_direct, drain;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        ram_en, ram_we;
  logic [4:0]  ram_addr;
  // Gating with the reset input keeps every grant and RAM strobe low while reset is held.
  assign idle   = rst_n_i && state_q == IDLE;
  assign starve = cnt_q == LIMIT;
`ifdef KAMIKAZE_RF_WRBUF_EN
  logic        buf_v_q, buf_v_d, wr_acc, wr_store;
  logic [4:0]  buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  assign drain          = idle && buf_v_q;
  assign bus.rd_ready_o = idle && !buf_v_q && (!bus.wr_valid_i || starve);
  assign rd_grant       = bus.rd_valid_i && bus.rd_ready_o;
  assign bus.wr_ready_o = rst_n_i && !buf_v_q;
  assign wr_acc         = bus.wr_valid_i && bus.wr_ready_o;
  assign wr_direct      = wr_acc && idle && !rd_grant;
  assign wr_store       = wr_acc && !wr_direct;
  assign wr_grant       = wr_direct || drain;
  assign wa             = drain ? buf_addr_q : bus.wr_addr_i;
  assign wd             = drain ? buf_data_q : bus.wr_data_i;
  always_comb begin
    buf_v_d    = buf_v_q ? !drain : wr_store;
    buf_addr_d = wr_store ? bus.wr_addr_i : buf_addr_q;
    buf_data_d = wr_store ? bus.wr_data_i : buf_data_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      buf_v_q    <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      buf_v_q    <= buf_v_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
`else
  assign drain          = 1'b0;
  assign bus.rd_ready_o = idle && (!bus.wr_valid_i || starve);
  assign rd_grant       = bus.rd_valid_i && bus.rd_ready_o;
  assign bus.wr_ready_o = idle && !rd_grant;
  assign wr_direct      = bus.wr_valid_i && bus.wr_ready_o;
  assign wr_grant       = wr_direct;
  assign wa             = bus.wr_addr_i;
  assign wd             = bus.wr_data_i;
`endif
  always_comb begin
    state_d  = state_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    cnt_d    = (rd_grant || !bus.rd_valid_i) ? '0 : (wr_grant && !starve) ? cnt_q + 4'd1 : cnt_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = wa;
    case (state_q)
      IDLE: begin
        if (rd_grant) begin
          state_d = RD1;
          addr1_d = bus.rd_addr1_i;
          addr2_d = bus.rd_addr2_i;
        end else if (wr_grant) begin
          ram_en = 1'b1;
          ram_we = wa != 5'd0;
        end
      end
      RD1: begin
        state_d  = RD2;
        ram_en   = 1'b1;
        ram_addr = addr1_q;
      end
      RD2: begin
        state_d  = RSP;
        ram_en   = 1'b1;
        ram_addr = addr2_q;
        data1_d  = addr1_q == 5'd0 ? '0 : bus.ram_rdata_i;
      end
      default: begin
        state_d = IDLE;
        data2_d = addr2_q == 5'd0 ? '0 : bus.ram_rdata_i;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr1_q <= '0;
      addr2_q <= '0;
      cnt_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      cnt_q   <= cnt_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      rsp_q   <= state_q == RSP;
    end
  assign bus.rd_rsp_valid_o = rsp_q;
  assign bus.rd_data1_o     = data1_q;
  assign bus.rd_data2_o     = data2_q;
  assign bus.ram_en_o       = ram_en;
  assign bus.ram_we_o       = ram_we;
  assign bus.ram_addr_o     = ram_addr;
  assign bus.ram_wdata_o    = wd;
endmodule

// File: doc/kamikaze_rf_sched.md
KAMIKAZE_RF_SCHED -- requirements
Module: kamikaze_rf_sched

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive write grants after which a pending read gets priority (legal 1..15).
REQ-002 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n_i  input  1  asynchronous active-low reset.
REQ-004 rd_valid_i / rd_ready_o  input / output  1 / 1  read-request handshake, transfer when both high at a rising edge.
REQ-005 rd_addr1_i, rd_addr2_i  input  5 each  source register indices.
REQ-006 rd_rsp_valid_o  output  1  one-cycle pulse, response data valid.
REQ-007 rd_data1_o, rd_data2_o  output  32 each  registered read results.
REQ-008 wr_valid_i / wr_ready_o  input / output  1 / 1  write-request handshake.
REQ-009 wr_addr_i, wr_data_i  input  5 / 32  destination index and data.
REQ-010 ram_en_o, ram_we_o  output  1 / 1  single-port RAM enable and write enable.
REQ-011 ram_addr_o, ram_wdata_o  output  5 / 32  RAM address and write data.
REQ-012 ram_rdata_i  input  32  RAM read data, valid one cycle after an enabled read.

Function
REQ-013 FSM states: IDLE, RD1, RD2, RSP; only IDLE accepts requests.
REQ-014 Read accepted at edge T: state RD1 in cycle T+1 (ram_en_o=1, ram_we_o=0, ram_addr_o=latched addr1); RD2 in T+2 (addr2; rd_data1_o <= ram_rdata_i at end of cycle); RSP in T+3 (rd_data2_o <= ram_rdata_i at end of cycle); IDLE in T+4 with rd_rsp_valid_o=1 for exactly that cycle.
REQ-015 Source index 0 yields result 0 regardless of ram_rdata_i; the RAM access is still performed.
REQ-016 rd_rsp_valid_o has no backpressure; rd_data1_o/rd_data2_o hold their value until the next response.
REQ-017 A write is accepted only in IDLE; in the accepting cycle ram_en_o=1, ram_addr_o=wr_addr_i, ram_wdata_o=wr_data_i, ram_we_o=1 if wr_addr_i!=0, else 0; state stays IDLE.
REQ-018 Writes to index 0 are accepted and discarded.
REQ-019 In IDLE with both requests valid, the write wins unless the starvation counter equals STARVE_LIMIT, in which case the read wins.
REQ-020 The starvation counter increments on each write grant while rd_valid_i=1, clears on any read grant or whenever rd_valid_i=0, and saturates at STARVE_LIMIT.
REQ-021 rd_ready_o = IDLE and (no write valid, or counter == STARVE_LIMIT).
REQ-022 wr_ready_o = IDLE and not read-granted this cycle (without buffer, see REQ-027).
REQ-023 ram_en_o=0 whenever no access is scheduled.
REQ-024 Read data reflects all writes granted before the read grant and no write granted after it.

Reset
REQ-025 Reset forces: IDLE, counter 0, rd_rsp_valid_o 0, rd_data1_o/rd_data2_o 0, ram_en_o 0, ram_we_o 0, write buffer empty.
REQ-026 Reset asserted mid-read abandons the sequence; no rd_rsp_valid_o pulse follows deassertion.

Configuration
REQ-027 Macro KAMIKAZE_RF_WRBUF_EN defined: a one-entry write buffer. wr_ready_o = buffer empty, in any state. A write accepted outside IDLE, or losing arbitration in IDLE, is stored. In IDLE a full buffer drains first (one RAM write cycle) with priority over new reads and writes. A drain counts as a write grant for REQ-020.
REQ-028 Macro undefined: no buffer; wr_ready_o follows REQ-022.

Verification
REQ-029 Write x5=0xDEADBEEF, then read (5,0) -> pulse 4 cycles after read grant, data1=0xDEADBEEF, data2=0.
REQ-030 Write x0=0x12345678 -> ram_we_o=0 on grant cycle; subsequent read (0,0) -> both 0.
REQ-031 rd_valid_i and wr_valid_i held high continuously with STARVE_LIMIT=4 -> read granted after exactly 4 write grants.
REQ-032 Reset asserted at RD2 -> IDLE, outputs 0, no response pulse after release.
REQ-033 With KAMIKAZE_RF_WRBUF_EN: write x3=0xA5A5A5A5 during RD1 of a read of (3,3) -> read returns the old x3; buffer drains in the next IDLE cycle; a following read of (3,3) returns 0xA5A5A5A5.
